// File: rtl/core_regfile_if.sv
// rtl/core_regfile_if.sv - writeback, operand-read and issue bundle for core_regfile
//
// Purpose: groups every non-clock/reset signal of core_regfile.
// Ports (members):
//   wr_a, wr_b    : writeback lines {ready, rd, value}, master -> slave
//   rs_addr[4]    : operand read addresses (0-1 slot A, 2-3 slot B), master -> slave
//   rs_data[4]    : operand read data (bypassed), slave -> master
//   rs_ready[4]   : operand has no outstanding write, slave -> master
//   issue_a/b_*   : issuing instruction destination + valid, master -> slave
//   issue_stall   : issue would overflow a pending counter, slave -> master
//   wb_conflict   : both write ports hit the same rd last cycle, slave -> master
interface core_regfile_if #(
  parameter int NREGS = 16,
  parameter int WIDTH = 32
);
  localparam int RW = $clog2(NREGS);

  typedef struct packed {
    logic             ready;
    logic [RW-1:0]    rd;
    logic [WIDTH-1:0] value;
  } wb_line;

  wb_line           wr_a;
  wb_line           wr_b;
  logic [RW-1:0]    rs_addr  [4];
  logic [WIDTH-1:0] rs_data  [4];
  logic             rs_ready [4];
  logic             issue_a_valid;
  logic             issue_b_valid;
  logic [RW-1:0]    issue_a_rd;
  logic [RW-1:0]    issue_b_rd;
  logic             issue_stall;
  logic             wb_conflict;

  modport master (
    output wr_a, wr_b, rs_addr, issue_a_valid, issue_b_valid, issue_a_rd, issue_b_rd,
    input  rs_data, rs_ready, issue_stall, wb_conflict
  );

  modport slave (
    input  wr_a, wr_b, rs_addr, issue_a_valid, issue_b_valid, issue_a_rd, issue_b_rd,
    output rs_data, rs_ready, issue_stall, wb_conflict
  );
endinterface

// File: rtl/core_regfile.sv
// rtl/core_regfile.sv - architectural register file with pending-write scoreboard
//
// Purpose: stores NREGS x WIDTH registers written by two writeback ports, serves
// four bypassed operand reads, and keeps a 2-bit pending-write counter per
// register so issue can see operand readiness and stall on counter overflow.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : core_regfile_if.slave (write ports, read ports, issue, status)
module core_regfile #(
  parameter int NREGS    = 16,
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  core_regfile_if.slave  bus
);
  localparam int RW = $clog2(NREGS);

  logic [WIDTH-1:0] regs     [NREGS];
  logic [1:0]       pend     [NREGS];
  logic [1:0]       pend_nxt [NREGS];
  logic [1:0]       ret      [NREGS];
  logic [1:0]       iss      [NREGS];
  logic             stall;
  logic             zero_en;
  logic             wr_a_ok;
  logic             wr_b_ok;

  assign zero_en = (ZERO_REG != 0);
  assign wr_a_ok = bus.wr_a.ready && !(zero_en && bus.wr_a.rd == '0);
  assign wr_b_ok = bus.wr_b.ready && !(zero_en && bus.wr_b.rd == '0);

  // pend + iss - ret in 3-bit signed arithmetic, clamped at zero
  function automatic logic [1:0] next_count(input logic [1:0] p, input logic [1:0] i,
                                            input logic [1:0] r);
    logic signed [2:0] t;
    t = $signed({1'b0, p}) + $signed({1'b0, i}) - $signed({1'b0, r});
    return t[2] ? 2'd0 : t[1:0];
  endfunction

  // Per-register retire/issue counts and the overflow check
  always_comb begin
    stall = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      ret[r] = {1'b0, bus.wr_a.ready && bus.wr_a.rd == RW'(r)}
             + {1'b0, bus.wr_b.ready && bus.wr_b.rd == RW'(r)};
      iss[r] = {1'b0, bus.issue_a_valid && bus.issue_a_rd == RW'(r)}
             + {1'b0, bus.issue_b_valid && bus.issue_b_rd == RW'(r)};
      if (zero_en && r == 0) iss[r] = 2'd0;
      // Ignores same-cycle retires on purpose: conservative stall
      if (({1'b0, pend[r]} + {1'b0, iss[r]}) > 3'd3) stall = 1'b1;
    end
  end

  // A stalled cycle discards both issues but still retires writebacks
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_nxt[r] = next_count(pend[r], stall ? 2'd0 : iss[r], ret[r]);
    end
  end

  assign bus.issue_stall = stall;

  // Operand reads: zero reg, then wr_b bypass, wr_a bypass, storage
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (zero_en && bus.rs_addr[i] == '0) begin
        bus.rs_data[i]  = '0;
        bus.rs_ready[i] = 1'b1;
      end else begin
        if (bus.wr_b.ready && bus.wr_b.rd == bus.rs_addr[i])
          bus.rs_data[i] = bus.wr_b.value;
        else if (bus.wr_a.ready && bus.wr_a.rd == bus.rs_addr[i])
          bus.rs_data[i] = bus.wr_a.value;
        else
          bus.rs_data[i] = regs[bus.rs_addr[i]];
        bus.rs_ready[i] = (pend[bus.rs_addr[i]] <= ret[bus.rs_addr[i]]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= 2'd0;
      end
      bus.wb_conflict <= 1'b0;
    end else begin
      // wr_b is written last so it wins on a shared rd
      if (wr_a_ok) regs[bus.wr_a.rd] <= bus.wr_a.value;
      if (wr_b_ok) regs[bus.wr_b.rd] <= bus.wr_b.value;
      for (int r = 0; r < NREGS; r++) pend[r] <= pend_nxt[r];
      bus.wb_conflict <= bus.wr_a.ready && bus.wr_b.ready && (bus.wr_a.rd == bus.wr_b.rd);
    end
  end
endmodule

// File: doc/core_regfile.md
# core_regfile

Architectural register file and pending-write scoreboard at the receiving end of the writeback stage. It consumes the two per-cycle register write ports (`wr_a`, `wr_b`) and serves four operand read ports, two per issue slot. Same-cycle writes are bypassed to the read ports. It tracks in-flight destination registers so issue can tell whether operands are ready and when it must stall.

## Interface
- `NREGS`, default 16: register count, power of two; index width `RW = $clog2(NREGS)`.
- `WIDTH`, default 32: data width.
- `ZERO_REG`, default 1: when 1, r0 reads 0, ignores writes and is never pending.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `wr_a`, `wr_b` in, `wb_line`: write ports; fields `ready` (1), `rd` (RW), `value` (WIDTH).
- `rs_addr[4]` in, 4×RW: read addresses; indices 0–1 are slot A operands, 2–3 are slot B operands.
- `rs_data[4]` out, 4×WIDTH: read data, combinational.
- `rs_ready[4]` out, 4×1: operand has no outstanding write, combinational.
- `issue_a_valid`, `issue_b_valid` in, 1: an instruction issues this cycle with destination `issue_a_rd` / `issue_b_rd`.
- `issue_a_rd`, `issue_b_rd` in, RW: destination register of the issuing instruction.
- `issue_stall` out, 1: issue would overflow a pending counter; combinational.
- `wb_conflict` out, 1: registered one-cycle pulse; `wr_a` and `wr_b` wrote the same register in the previous cycle.

## Operation
- Storage: `NREGS`×`WIDTH` flops. Each register also has a 2-bit pending counter `pend[r]` (0–3).
- **Writes:** a port with `ready=1` writes `value` to `rd` at the clock edge.
  - If both ports target the same `rd`, `wr_b` wins and `wb_conflict` pulses the next cycle.
  - When `ZERO_REG=1`, writes to r0 are dropped.
- **Reads:** `rs_data[i]` returns, in priority order:
  - 0, if `ZERO_REG=1` and the address is r0;
  - else `wr_b.value`, if `wr_b.ready` and `wr_b.rd` matches;
  - else `wr_a.value`, if `wr_a.ready` and `wr_a.rd` matches;
  - else the stored value.
- **Retire count:** `ret[r]` = number of write ports with `ready=1` targeting r this cycle (0–2).
- **Operand ready:** `rs_ready[i]` = `pend[r] <= ret[r]`; r0 is always ready when `ZERO_REG=1`.
- **Issue count:** `iss[r]` = number of issue slots (`issue_a_valid` / `issue_b_valid`) targeting r (0–2).
- **Stall:** `issue_stall` = 1 if any r has `pend[r] + iss[r] > 3`. The comparison uses 3-bit arithmetic and ignores same-cycle retires (conservative).
- **Counter update when `issue_stall=0`:** `pend[r] <= max(0, pend[r] + iss[r] - ret[r])`.
  - Computed in 3-bit signed arithmetic, clamped at 0.
  - A writeback to a register with no pending writes still writes data; the counter stays 0, with no underflow wrap.
- **Counter update when `issue_stall=1`:** issues are discarded and `pend[r] <= max(0, pend[r] - ret[r])`. Writes proceed normally.
- Issue to r0 never increments when `ZERO_REG=1`.

## Timing
- **Reset (async assert, sync release):**
  - all registers = 0;
  - all `pend` = 0;
  - `wb_conflict` = 0.
- **Reset combinational outputs:** `issue_stall` = 0; `rs_ready` = 1 for all ports; `rs_data` = 0 unless a write port is `ready` (bypass still applies).
- Write latency: 0 cycles to the read ports (bypass); data is in storage after 1 edge.
- Scoreboard latency: an issue at cycle N makes `rs_ready` = 0 for that register from cycle N+1 until its writeback cycle, where it reads ready via bypass.
- Issue and retire on the same register in the same cycle: the counter is unchanged.
- Reset mid-operation: all pending state is lost. Upstream pipelines must be reset together.

## Test plan
- **Reset/readback:** release reset; `rs_addr[0..3]` = 1,2,3,4 -> `rs_data` = 0 and `rs_ready` = 1. Then write `wr_a`{1, r5, 0xDEADBEEF} and read r5 in the same cycle -> 0xDEADBEEF; read again the next cycle -> 0xDEADBEEF.
- **Dual-write conflict:** `wr_a`{1, r3, 0x11} and `wr_b`{1, r3, 0x22} in one cycle -> bypass reads 0x22; next cycle stored r3 = 0x22 and `wb_conflict` = 1 for exactly one cycle.
- **Zero register:** `ZERO_REG=1`; write 0x1234 to r0 and issue to r0 -> r0 reads 0, `rs_ready` = 1, `issue_stall` = 0.
- **Scoreboard:**
  - issue A to r7 at cycle 0 -> `rs_ready`(r7) = 0 at cycle 1;
  - writeback to r7 at cycle 4 -> `rs_ready` = 1 at cycle 4 with bypassed data;
  - `pend[r7]` = 0 at cycle 5.
- **Saturation stall:** issue to r9 three times (`pend` = 3), then issue A to r9 -> `issue_stall` = 1 and `pend` stays 3. Repeat the issue with a simultaneous writeback to r9 -> still stalled, `pend` = 2. Issue again -> `pend` = 3.
- **Underflow and same-cycle events:**
  - writeback to r2 with `pend` = 0 -> data stored, `pend` stays 0;
  - with `pend[r4]` = 1, issue A to r4 plus writeback to r4 in the same cycle -> `pend[r4]` stays 1.
